pwm_multi_generator: RTL and testbench
======================================

PWM_MULTI_GENERATOR -- requirements
Module: pwm_multi_generator

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent PWM outputs, range 1..16.
REQ-002 Parameter PWM_WIDTH, default 10: duty resolution in bits; period = 2^PWM_WIDTH ticks.
REQ-003 Parameter PRESCALE_WIDTH, default 12: width of t_lsb.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 sync_signal  input  1  asynchronous resync request; a rising edge restarts the period.
REQ-007 t_lsb  input  PRESCALE_WIDTH  tick length minus one, in clk cycles.
REQ-008 wr_en  input  1  single-cycle duty write strobe.
REQ-009 wr_chan  input  max(1,$clog2(CHANNELS))  target channel of the write.
REQ-010 wr_value  input  PWM_WIDTH  new duty value.
REQ-011 pwm_signal  output  CHANNELS  PWM outputs, bit i = channel i, registered.
REQ-012 period_start  output  1  one-cycle pulse in the cycle the period counter is 0 with a tick.

Function
REQ-013 Prescaler SHALL count 0..t_lsb and assert an internal tick in the cycle it equals t_lsb, then wrap to 0; t_lsb=0 gives a tick every cycle.
REQ-014 t_lsb SHALL be sampled into the prescaler compare only at prescaler wrap, sync restart or reset exit.
REQ-015 Period counter (PWM_WIDTH bits) SHALL increment on each tick and wrap from 2^PWM_WIDTH-1 to 0.
REQ-016 Each channel SHALL hold a shadow and an active duty register, both PWM_WIDTH bits.
REQ-017 wr_en=1 SHALL load wr_value into shadow[wr_chan] at that clock edge; wr_chan >= CHANNELS SHALL be ignored.
REQ-018 All shadows SHALL be copied to active registers at period wrap (tick with counter = 2^PWM_WIDTH-1) and at sync restart.
REQ-019 A write in the same cycle as a commit SHALL be written to the shadow and committed at the next commit, not the current one.
REQ-020 pwm_signal[i] SHALL be 1 while phase counter of channel i < active[i]; active=0 gives constant 0; active=2^PWM_WIDTH-1 gives low for exactly one tick per period.
REQ-021 pwm_signal SHALL be registered: one clk of latency from the counter/compare to the output pin.
REQ-022 sync_signal SHALL pass through a 2-flop synchroniser plus edge detect; prescaler and period counter SHALL be 0 on the 3rd clk edge after sync_signal is first sampled high.
REQ-023 Sync restart SHALL override a simultaneous natural wrap; a commit SHALL occur exactly once.
REQ-024 A sync_signal held high SHALL cause one restart only; the next restart requires a low then high.
REQ-025 period_start SHALL pulse once per period, including the first period after sync restart.

Reset
REQ-026 With reset low: prescaler, period counter, shadows, active registers, synchroniser flops = 0; pwm_signal = 0; period_start = 0.
REQ-027 Reset asserted mid-period SHALL clear outputs immediately (asynchronously); counting resumes from 0 on the first clk edge after release.

Configuration
REQ-028 Macro PWM_PHASE_STAGGER_EN defined: channel i phase counter = period counter + i*(2^PWM_WIDTH/CHANNELS), modulo 2^PWM_WIDTH, interleaving edges across channels.
REQ-029 Macro PWM_PHASE_STAGGER_EN undefined: all channels use the period counter directly; all rising edges are aligned at the period start.
REQ-030 The shadow commit point SHALL remain the global period wrap in both builds.

Verification
REQ-031 CHANNELS=4, PWM_WIDTH=10, t_lsb=0, write ch0=512 -> after the next commit, pwm_signal[0] high 512 clk, low 512 clk, repeating.
REQ-032 t_lsb=407, ch1=256 -> high 256*408 clk, period 1024*408 clk; period_start spacing = 417792 clk.
REQ-033 Write ch2=100 mid-period, then ch2=200 before wrap -> current period unchanged; next period duty 200.
REQ-034 sync_signal rising edge mid-period -> counters 0 on the 3rd edge, shadows committed, period_start pulses once; held-high sync gives no second restart.
REQ-035 Reset pulled low mid-period with duties set -> pwm_signal=0 immediately; after release all channels stay 0 until new writes are committed.
REQ-036 PWM_PHASE_STAGGER_EN defined, all duties 256 -> channel i rising edge offset by i*256 ticks from channel 0; undefined -> all rising edges coincident.

Source files
------------

// File: rtl/pwm_multi_generator.sv
`timescale 1ns/1ps
// Multi-channel PWM generator: shared prescaler and period counter, shadowed per-channel duty,
// resync input. Define PWM_PHASE_STAGGER_EN to spread channel phases evenly over the period.
module pwm_multi_generator #(
  parameter int CHANNELS       = 4,
  parameter int PWM_WIDTH      = 10,
  parameter int PRESCALE_WIDTH = 12,
  localparam int CHAN_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sync_signal,
  input  logic [PRESCALE_WIDTH-1:0] t_lsb,
  input  logic                      wr_en,
  input  logic [CHAN_W-1:0]         wr_chan,
  input  logic [PWM_WIDTH-1:0]      wr_value,
  output logic [CHANNELS-1:0]       pwm_signal,
  output logic                      period_start
);

  localparam int PERIOD = 2 ** PWM_WIDTH;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int PHASE_STEP = PERIOD / CHANNELS;
`else
  localparam int PHASE_STEP = 0;
`endif

  logic                      sync_q1, sync_q2, sync_q3, sync_rise;
  logic                      run;
  logic [PRESCALE_WIDTH-1:0] presc, t_cmp, cmp_eff;
  logic [PWM_WIDTH-1:0]      cnt;
  logic                      tick, wrap, commit;
  logic [PWM_WIDTH-1:0]      shadow [CHANNELS];
  logic [PWM_WIDTH-1:0]      active [CHANNELS];
  logic [CHANNELS-1:0]       pwm_next;

  assign sync_rise = sync_q2 & ~sync_q3;
  // Until the first edge after reset the compare value has not been captured yet.
  assign cmp_eff   = run ? t_cmp : t_lsb;
  assign tick      = (presc == cmp_eff);
  assign wrap      = tick & (cnt == '1);
  assign commit    = sync_rise | wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
    end else begin
      sync_q1 <= sync_signal;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
    end
  end

  // A resync wins over a natural wrap in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      t_cmp <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (sync_rise) begin
        presc <= '0;
        cnt   <= '0;
        t_cmp <= t_lsb;
      end else if (tick) begin
        presc <= '0;
        cnt   <= cnt + PWM_WIDTH'(1);
        t_cmp <= t_lsb;
      end else begin
        presc <= presc + PRESCALE_WIDTH'(1);
        if (!run) t_cmp <= t_lsb;
      end
    end
  end

  // Commit copies the pre-edge shadow, so a same-cycle write waits for the next commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (commit) active[i] <= shadow[i];
        if (wr_en && (wr_chan == CHAN_W'(i))) shadow[i] <= wr_value;
      end
    end
  end

  always_comb begin
    logic [PWM_WIDTH-1:0] phase;
    phase    = '0;
    pwm_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      phase       = cnt + PWM_WIDTH'(i * PHASE_STEP);
      pwm_next[i] = (phase < active[i]);
    end
  end

  // period_start is registered alongside pwm_signal so both describe the same counter cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_signal   <= '0;
      period_start <= 1'b0;
    end else begin
      pwm_signal   <= pwm_next;
      period_start <= tick & (cnt == '0) & ~sync_rise;
    end
  end

endmodule

// File: tb/tb_pwm_multi_generator.sv
`timescale 1ns/1ps
// Bench for pwm_multi_generator: cycle-level behavioural model with an expected queue,
// randomized traffic, and hand-computed duty/period/offset expectations.
module tb_pwm_multi_generator;

  localparam int CHANNELS = 4;
  localparam int PWM_WIDTH = 10;
  localparam int PRESCALE_WIDTH = 12;
  localparam int PERIOD = 1024;
  localparam int W = CHANNELS + 1;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int STEP = PERIOD / CHANNELS;
`else
  localparam int STEP = 0;
`endif

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      sync_signal = 1'b0;
  logic [PRESCALE_WIDTH-1:0] t_lsb = '0;
  logic                      wr_en = 1'b0;
  logic [1:0]                wr_chan = '0;
  logic [PWM_WIDTH-1:0]      wr_value = '0;
  logic [CHANNELS-1:0]       pwm_signal;
  logic                      period_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  pwm_multi_generator #(
    .CHANNELS(CHANNELS), .PWM_WIDTH(PWM_WIDTH), .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .sync_signal(sync_signal), .t_lsb(t_lsb),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_value(wr_value),
    .pwm_signal(pwm_signal), .period_start(period_start)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // behavioural model
  int m_presc = 0, m_cmp = 0, m_cnt = 0;
  bit m_first = 1'b1;
  int m_shadow [CHANNELS];
  int m_active [CHANNELS];
  bit sync_hist [$] = '{1'b0, 1'b0, 1'b0};
  logic [W-1:0] exp_q [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_presc = 0; m_cmp = 0; m_cnt = 0; m_first = 1'b1;
      foreach (m_shadow[i]) begin m_shadow[i] = 0; m_active[i] = 0; end
      sync_hist = '{1'b0, 1'b0, 1'b0};
      exp_q.delete();
    end else begin : step
      bit restart, tick, commit;
      int cmp;
      logic [W-1:0] e;
      // the restart lands two edges after the first high sample following a low one
      restart = sync_hist[sync_hist.size()-2] && !sync_hist[sync_hist.size()-3];
      cmp = m_first ? int'(t_lsb) : m_cmp;
      tick = (m_presc == cmp);
      commit = restart || (tick && m_cnt == PERIOD - 1);
      for (int i = 0; i < CHANNELS; i++) e[i] = (((m_cnt + i * STEP) % PERIOD) < m_active[i]);
      e[CHANNELS] = tick && (m_cnt == 0) && !restart;
      exp_q.push_back(e);
      if (restart) begin
        m_presc = 0; m_cnt = 0; m_cmp = int'(t_lsb);
      end else if (tick) begin
        m_presc = 0; m_cnt = (m_cnt + 1) % PERIOD; m_cmp = int'(t_lsb);
      end else begin
        m_presc++;
        if (m_first) m_cmp = int'(t_lsb);
      end
      m_first = 1'b0;
      if (commit) foreach (m_active[i]) m_active[i] = m_shadow[i];
      if (wr_en && int'(wr_chan) < CHANNELS) m_shadow[wr_chan] = int'(wr_value);
      sync_hist.push_back(sync_signal);
      void'(sync_hist.pop_front());
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin : compare
    logic [W-1:0] e;
    bit have;
    have = 1'b1;
    e = '0;
    if (reset) begin
      if (exp_q.size() == 0) begin
        checks++; errors++; have = 1'b0;
        $display("FAIL model_queue_empty cyc=%0d actual=empty required=entry", cyc);
      end else e = exp_q.pop_front();
    end
    if (have) begin
      checks++;
      if ({period_start, pwm_signal} !== e) begin
        errors++;
        $display("FAIL cycle_compare cyc=%0d actual=%b required=%b", cyc, {period_start, pwm_signal}, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int ch, input int val);
    @(negedge clk);
    wr_en = 1'b1; wr_chan = 2'(ch); wr_value = 10'(val);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(output int at);
    at = -1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (period_start) begin at = cyc; return; end
    end
    chk("period_start_timeout", 0, 1);
  endtask

  task automatic measure(input int ch, output int hi, output int lo);
    logic prev;
    int k;
    hi = 0; lo = 0; k = 0;
    prev = pwm_signal[ch];
    while (k < 20000) begin
      @(negedge clk);
      if (pwm_signal[ch] && !prev) break;
      prev = pwm_signal[ch];
      k++;
    end
    if (k >= 20000) begin chk("rise_timeout", 0, 1); return; end
    hi = 1;
    while (hi < 20000) begin
      @(negedge clk);
      if (!pwm_signal[ch]) break;
      hi++;
    end
    lo = 1;
    while (lo < 20000) begin
      @(negedge clk);
      if (pwm_signal[ch]) break;
      lo++;
    end
  endtask

  task automatic check_rise_offsets();
    logic [CHANNELS-1:0] prev, cur;
    int rise_at [CHANNELS];
    int k;
    foreach (rise_at[i]) rise_at[i] = -1;
    prev = pwm_signal; cur = pwm_signal; k = 0;
    while (!(cur[0] && !prev[0]) && k < 5000) begin
      prev = cur; @(negedge clk); cur = pwm_signal; k++;
    end
    if (k >= 5000) chk("ch0_rise_timeout", 0, 1);
    for (int j = 0; j < 1100; j++) begin
      for (int i = 0; i < CHANNELS; i++)
        if (cur[i] && !prev[i] && rise_at[i] < 0) rise_at[i] = j;
      prev = cur; @(negedge clk); cur = pwm_signal;
    end
    for (int i = 0; i < CHANNELS; i++)
      chk($sformatf("rise_offset_ch%0d", i), rise_at[i], (PERIOD - i * STEP) % PERIOD);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi, lo, a, b, k, cnt_hi;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm_signal), 0);
    chk("reset_period_start", int'(period_start), 0);
    #2 reset = 1'b1;

    // basic duties at t_lsb=0
    write(0, 512); write(1, 256); write(2, 0); write(3, 1023);
    measure(0, hi, lo); chk("ch0_512_high", hi, 512); chk("ch0_512_low", lo, 512);
    measure(3, hi, lo); chk("ch3_max_high", hi, 1023); chk("ch3_max_low", lo, 1);
    measure(1, hi, lo); chk("ch1_256_high", hi, 256); chk("ch1_256_low", lo, 768);

    // two writes in one period: current period untouched, next uses the last value
    wait_ps(a); tick_n(10); write(2, 100); tick_n(100); write(2, 200);
    cnt_hi = 0; k = 0;
    while (!period_start && k < 2000) begin
      if (pwm_signal[2]) cnt_hi++;
      @(negedge clk); k++;
    end
    chk("ch2_current_period_high", cnt_hi, 0);
    measure(2, hi, lo); chk("ch2_next_high", hi, 200); chk("ch2_next_low", lo, 824);

    // resync mid-period, held high
    wait_ps(a); tick_n(300); write(1, 700);
    @(negedge clk); sync_signal = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk); k++;
      if (period_start) break;
    end
    chk("sync_to_period_start", k, 4);
    a = cyc; wait_ps(b);
    chk("sync_held_no_restart", b - a, PERIOD);
    measure(1, hi, lo); chk("sync_commit_high", hi, 700); chk("sync_commit_low", lo, 324);
    @(negedge clk); sync_signal = 1'b0;

    // phase offsets with equal duties
    for (int i = 0; i < CHANNELS; i++) write(i, 256);
    wait_ps(a); wait_ps(b);
    check_rise_offsets();

    // write landing exactly on the commit edge
    wait_ps(a); tick_n(1021); write(0, 100);
    measure(0, hi, lo); chk("commit_same_cycle_current", hi, 256);
    measure(0, hi, lo); chk("commit_same_cycle_next", hi, 100);

    // randomized traffic, checked by the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_chan = 2'($urandom_range(0, CHANNELS - 1));
      wr_value = 10'($urandom_range(0, PERIOD - 1));
      if ($urandom_range(0, 299) == 0) t_lsb = 12'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) sync_signal = ~sync_signal;
    end
    @(negedge clk); wr_en = 1'b0; sync_signal = 1'b0; t_lsb = '0;

    // asynchronous reset mid-period
    for (int i = 0; i < CHANNELS; i++) write(i, 512);
    wait_ps(a); wait_ps(b); tick_n(200);
    #2 reset = 1'b0;
    #1 chk("async_reset_pwm", int'(pwm_signal), 0);
    chk("async_reset_period_start", int'(period_start), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    tick_n(1100);
    chk("after_reset_pwm_zero", int'(pwm_signal), 0);

    // prescaled period
    t_lsb = 12'd3;
    write(1, 256);
    wait_ps(a); wait_ps(b);
    chk("prescaled_period_spacing", b - a, 4096);
    measure(1, hi, lo); chk("prescaled_ch1_high", hi, 1024); chk("prescaled_ch1_low", lo, 3072);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
